// File: rtl/issue_select_pkg.sv
// Shared types and constants for the issue_select slice.
package issue_select_pkg;

  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned NUM_COLS = 8;
  localparam int unsigned NUM_FUS  = 4;
  localparam int unsigned MAX_LAT  = 4;

  localparam int unsigned ROW_W = $clog2(NUM_ROWS);
  localparam int unsigned FU_W  = $clog2(NUM_FUS);
  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

  typedef logic [ROW_W-1:0] row_idx_t;
  typedef logic [FU_W-1:0]  fu_id_t;
  typedef logic [LAT_W-1:0] lat_t;

  typedef struct packed {
    logic     valid;
    row_idx_t row;
    fu_id_t   fu;
  } issue_pkt_t;

endpackage

// File: rtl/issue_select_age_matrix.sv
// Age matrix for oldest-first selection; built only with ISSUE_SELECT_AGE_EN.
`ifdef ISSUE_SELECT_AGE_EN
module issue_select_age_matrix
  import issue_select_pkg::*;
#(
  parameter int unsigned N = NUM_ROWS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic [$clog2(N)-1:0] alloc_row,
  input  logic [N-1:0]         valid,
  input  logic [N-1:0]         eligible,
  output logic [N-1:0]         oldest_grant
);

  // older[r][j] = 1 : row j is older than row r
  logic [N-1:0] older [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < N; r++) older[r] <= '0;
    end else if (alloc_en) begin
      for (int unsigned j = 0; j < N; j++) begin
        older[alloc_row][j] <= (j != 32'(alloc_row)) ? valid[j] : 1'b0;
        older[j][alloc_row] <= 1'b0;
      end
    end
  end

  always_comb begin
    oldest_grant = '0;
    for (int unsigned r = 0; r < N; r++)
      oldest_grant[r] = eligible[r] & ~|(older[r] & eligible);
  end

endmodule
`endif

// File: rtl/issue_select.sv
// Issue select stage: picks one ready row per cycle, emits the issue/free
// packet and times each producer's latency to drive clear_lines.
// Macro ISSUE_SELECT_AGE_EN: oldest-first via age matrix; otherwise lowest index.
module issue_select
  import issue_select_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_en,
  input  logic [ROW_W-1:0]             alloc_row_index,
  input  logic [FU_W-1:0]              alloc_fu,
  input  logic [LAT_W-1:0]             alloc_lat,
  input  logic [NUM_ROWS-1:0]          request_vector,
  input  logic [NUM_FUS-1:0]           fu_ready,
  output logic                         issue_valid,
  output logic [ROW_W-1:0]             issue_row_index,
  output logic [FU_W-1:0]              issue_fu,
  output logic                         free_en,
  output logic [ROW_W-1:0]             free_row_index,
  output logic                         clear_en,
  output logic [NUM_COLS*NUM_FUS-1:0]  clear_lines
);

  logic [NUM_ROWS-1:0] valid_q, issued_q, eligible, grant;
  fu_id_t              fu_q    [NUM_ROWS];
  lat_t                lat_q   [NUM_ROWS];
  lat_t                col_cnt [NUM_COLS];
  fu_id_t              col_fu  [NUM_COLS];
  issue_pkt_t          win, pkt_q;
  logic [NUM_COLS*NUM_FUS-1:0] clear_d, clear_q;
  logic                clear_en_q;
  logic                alloc_ok;

  assign alloc_ok = alloc_en & ~flush;

  always_comb begin
    eligible = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++)
      eligible[r] = valid_q[r] & ~issued_q[r] & request_vector[r] & fu_ready[fu_q[r]];
  end

`ifdef ISSUE_SELECT_AGE_EN
  issue_select_age_matrix #(.N(NUM_ROWS)) u_age (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_ok),
    .alloc_row    (alloc_row_index),
    .valid        (valid_q),
    .eligible     (eligible),
    .oldest_grant (grant)
  );
`else
  // two's-complement trick isolates the lowest set bit
  always_comb grant = eligible & (~eligible + {{(NUM_ROWS-1){1'b0}}, 1'b1});
`endif

  always_comb begin
    win = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (grant[r]) begin
        win.valid = 1'b1;
        win.row   = row_idx_t'(r);
        win.fu    = fu_q[r];
      end
    end
  end

  // Counters load lat-1 so "holds 1" marks the last cycle before the clear is
  // visible; lat=1 clears straight from the grant alongside the issue packet.
  always_comb begin
    clear_d = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      for (int unsigned f = 0; f < NUM_FUS; f++) begin
        clear_d[f*NUM_COLS+c] =
            (col_cnt[c] == lat_t'(1) && col_fu[c] == fu_id_t'(f)) ||
            (grant[c] && lat_q[c] == lat_t'(1) && fu_q[c] == fu_id_t'(f));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      issued_q   <= '0;
      pkt_q      <= '0;
      clear_q    <= '0;
      clear_en_q <= 1'b0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        fu_q[r]  <= '0;
        lat_q[r] <= '0;
      end
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        col_cnt[c] <= '0;
        col_fu[c]  <= '0;
      end
    end else if (flush) begin
      valid_q    <= '0;
      issued_q   <= '0;
      pkt_q      <= '0;
      clear_q    <= '0;
      clear_en_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_COLS; c++) col_cnt[c] <= '0;
    end else begin
      pkt_q      <= win;
      clear_q    <= clear_d;
      clear_en_q <= |clear_d;
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        if (grant[c]) begin
          col_cnt[c] <= lat_q[c] - lat_t'(1);
          col_fu[c]  <= fu_q[c];
        end else if (col_cnt[c] != '0) begin
          col_cnt[c] <= col_cnt[c] - lat_t'(1);
        end
      end
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        if (grant[r]) begin
          valid_q[r]  <= 1'b0;
          issued_q[r] <= 1'b1;
        end
      end
      if (alloc_en) begin
        valid_q[alloc_row_index]  <= 1'b1;
        issued_q[alloc_row_index] <= 1'b0;
        fu_q[alloc_row_index]     <= alloc_fu;
        lat_q[alloc_row_index]    <= alloc_lat;
      end
    end
  end

  assign issue_valid     = pkt_q.valid;
  assign issue_row_index = pkt_q.row;
  assign issue_fu        = pkt_q.fu;
  assign free_en         = pkt_q.valid;
  assign free_row_index  = pkt_q.row;
  assign clear_lines     = clear_q;
  assign clear_en        = clear_en_q;

  a_alloc_free: assert property (@(posedge clk) disable iff (!rst)
    alloc_ok |-> (!valid_q[alloc_row_index] || grant[alloc_row_index]));

  a_alloc_lat: assert property (@(posedge clk) disable iff (!rst)
    alloc_ok |-> (alloc_lat != '0 && alloc_lat <= lat_t'(MAX_LAT)));

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select; expectations follow ISSUE_SELECT_AGE_EN.
module tb_issue_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_en;
  logic [2:0]  alloc_row_index;
  logic [1:0]  alloc_fu;
  logic [2:0]  alloc_lat;
  logic [7:0]  request_vector;
  logic [3:0]  fu_ready;
  logic        issue_valid;
  logic [2:0]  issue_row_index;
  logic [1:0]  issue_fu;
  logic        free_en;
  logic [2:0]  free_row_index;
  logic        clear_en;
  logic [31:0] clear_lines;

  int tests = 0;
  int fails = 0;

  issue_select dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .alloc_en        (alloc_en),
    .alloc_row_index (alloc_row_index),
    .alloc_fu        (alloc_fu),
    .alloc_lat       (alloc_lat),
    .request_vector  (request_vector),
    .fu_ready        (fu_ready),
    .issue_valid     (issue_valid),
    .issue_row_index (issue_row_index),
    .issue_fu        (issue_fu),
    .free_en         (free_en),
    .free_row_index  (free_row_index),
    .clear_en        (clear_en),
    .clear_lines     (clear_lines)
  );

  always #5 clk = ~clk;

  // inputs for one cycle and the outputs expected in the following cycle
  typedef struct {
    logic        fl;
    logic        al;
    logic [2:0]  arow;
    logic [1:0]  afu;
    logic [2:0]  alat;
    logic [7:0]  req;
    logic [3:0]  fur;
    logic        ev;
    logic [2:0]  erow;
    logic [1:0]  efu;
    logic [31:0] eclr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic fl, input logic al, input logic [2:0] arow,
                               input logic [1:0] afu, input logic [2:0] alat,
                               input logic [7:0] req, input logic [3:0] fur,
                               input logic ev, input logic [2:0] erow,
                               input logic [1:0] efu, input logic [31:0] eclr);
    vec_t v;
    v.fl = fl; v.al = al; v.arow = arow; v.afu = afu; v.alat = alat;
    v.req = req; v.fur = fur; v.ev = ev; v.erow = erow; v.efu = efu; v.eclr = eclr;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_zero(input string name, input int idx);
    logic [42:0] act;
    act = {issue_valid, issue_row_index, issue_fu, free_en, free_row_index,
           clear_en, clear_lines};
    check(name, idx, 64'(act), 64'd0);
  endtask

  task automatic apply(input vec_t v, input string name, input int idx);
    logic [42:0] act, exp;
    @(negedge clk);
    flush = v.fl; alloc_en = v.al; alloc_row_index = v.arow; alloc_fu = v.afu;
    alloc_lat = v.alat; request_vector = v.req; fu_ready = v.fur;
    @(posedge clk);
    #1;
    exp = {v.ev, v.ev, |v.eclr, v.ev ? {v.erow, v.efu, v.erow} : 8'h00, v.eclr};
    act = {issue_valid, free_en, clear_en,
           v.ev ? {issue_row_index, issue_fu, free_row_index} : 8'h00, clear_lines};
    check(name, idx, 64'(act), 64'(exp));
  endtask

  initial begin
    vec_t idle;
    rst = 1'b0; flush = 1'b0; alloc_en = 1'b0; alloc_row_index = '0;
    alloc_fu = '0; alloc_lat = 3'd1; request_vector = '0; fu_ready = '0;
    idle = mkv(0, 0, 0, 0, 1, 8'h00, 4'hF, 0, 0, 0, 0);

    // reset then idle
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero("reset_hold", i);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) apply(idle, "idle", i);

    // oldest-first / fixed priority
    tbl.push_back(mkv(0, 1, 5, 0, 1, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 2, 0, 1, 8'h00, 4'hF, 0, 0, 0, 0));
`ifdef ISSUE_SELECT_AGE_EN
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h24, 4'hF, 1, 5, 0, 32'h1 << 5));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h24, 4'hF, 1, 2, 0, 32'h1 << 2));
`else
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h24, 4'hF, 1, 2, 0, 32'h1 << 2));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h24, 4'hF, 1, 5, 0, 32'h1 << 5));
`endif
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h24, 4'hF, 0, 0, 0, 0));
    // FU backpressure
    tbl.push_back(mkv(0, 1, 1, 2, 2, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 3, 1, 1, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h0A, 4'hB, 1, 3, 1, 32'h1 << 11));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h0A, 4'hB, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h0A, 4'hF, 1, 1, 2, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h00, 4'hF, 0, 0, 0, 32'h1 << 17));
    // latency 3
    tbl.push_back(mkv(0, 1, 4, 3, 3, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h10, 4'hF, 1, 4, 3, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h00, 4'hF, 0, 0, 0, 32'h1 << 28));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h00, 4'hF, 0, 0, 0, 0));
    // overlapping clears
    tbl.push_back(mkv(0, 1, 0, 1, 3, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 6, 1, 2, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h01, 4'hF, 1, 0, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h40, 4'hF, 1, 6, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h00, 4'hF, 0, 0, 0, 32'h0000_4100));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h00, 4'hF, 0, 0, 0, 0));
    // alloc of a row in the cycle it issues: new entry survives
    tbl.push_back(mkv(0, 1, 2, 0, 1, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 2, 2, 1, 8'h04, 4'hF, 1, 2, 0, 32'h1 << 2));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h04, 4'hF, 1, 2, 2, 32'h1 << 18));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h04, 4'hF, 0, 0, 0, 0));
    // flush mid-flight, alloc during flush ignored
    tbl.push_back(mkv(0, 1, 7, 0, 4, 8'h00, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h80, 4'hF, 1, 7, 0, 0));
    tbl.push_back(mkv(1, 1, 3, 0, 1, 8'h88, 4'hF, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h88, 4'hF, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], "vec", i);

    // reset pulse mid-flight
    apply(mkv(0, 1, 7, 0, 4, 8'h00, 4'hF, 0, 0, 0, 0), "rstflt", 0);
    apply(mkv(0, 0, 0, 0, 1, 8'h80, 4'hF, 1, 7, 0, 0), "rstflt", 1);
    apply(mkv(0, 0, 0, 0, 1, 8'h80, 4'hF, 0, 0, 0, 0), "rstflt", 2);
    @(negedge clk);
    alloc_en = 1'b0;
    request_vector = 8'h80;
    #2 rst = 1'b0;
    #1 check_zero("rstflt_async", 0);
    @(posedge clk);
    #1 check_zero("rstflt_async", 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++)
      apply(mkv(0, 0, 0, 0, 1, 8'h80, 4'hF, 0, 0, 0, 0), "rstflt_after", i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
